// File: rtl/avalon_ibex_responder_mem_pkg.sv
// Shared types for the Avalon-MM responder memory: response codes, the
// response-pipe entry and the byte-lane merge helper used on RAM writes.
package avalon_ibex_responder_mem_pkg;

  localparam int DataWidth = 32;
  localparam int NumLanes  = DataWidth / 8;

  typedef enum logic [1:0] {
    OKAY        = 2'd0,
    RESERVED    = 2'd1,
    SLAVEERROR  = 2'd2,
    DECODEERROR = 2'd3
  } resp_e;

  typedef struct packed {
    logic                 valid;
    logic [DataWidth-1:0] rdata;
    resp_e                resp;
  } rsp_t;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [DataWidth-1:0] be_merge(
    input logic [DataWidth-1:0] old_word,
    input logic [DataWidth-1:0] new_word,
    input logic [NumLanes-1:0]  be
  );
    logic [DataWidth-1:0] res;
    res = old_word;
    for (int b = 0; b < NumLanes; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/avalon_ibex_responder_mem_if.sv
// Avalon-MM slave-side bus bundle. The master modport is the bus driver
// (translator or bench); the slave modport is the responder memory.
interface avalon_ibex_responder_mem_if
  import avalon_ibex_responder_mem_pkg::*;
#(
  parameter int AddrWidth = 30
) ();

  logic [AddrWidth-1:0] avs_address;
  logic                 avs_read;
  logic                 avs_write;
  logic [3:0]           avs_byteenable;
  logic [31:0]          avs_writedata;
  logic                 avs_waitrequest;
  logic [31:0]          avs_readdata;
  logic                 avs_readdatavalid;
  resp_e                avs_response;

  modport master (
    output avs_address, avs_read, avs_write, avs_byteenable, avs_writedata,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid, avs_response
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_byteenable, avs_writedata,
    output avs_waitrequest, avs_readdata, avs_readdatavalid, avs_response
  );

endinterface

// File: rtl/avalon_ibex_responder_mem_rsp_pipe.sv
// Fixed-latency read response pipe. Only the valid bits are reset so that an
// in-flight read is dropped on reset; payload bits simply shift along.
module avalon_ibex_responder_mem_rsp_pipe
  import avalon_ibex_responder_mem_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  rsp_t rsp_i,
  output rsp_t rsp_o
);

  logic [Depth-1:0]     valid_q;
  logic [DataWidth-1:0] rdata_q [Depth];
  resp_e                resp_q  [Depth];

  // Valid bits shift one stage per cycle and are cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= rsp_i.valid;
      for (int i = 1; i < Depth; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Payload shifts alongside the valid bits without reset.
  always_ff @(posedge clk_i) begin
    rdata_q[0] <= rsp_i.rdata;
    resp_q[0]  <= rsp_i.resp;
    for (int i = 1; i < Depth; i++) begin
      rdata_q[i] <= rdata_q[i-1];
      resp_q[i]  <= resp_q[i-1];
    end
  end

  assign rsp_o.valid = valid_q[Depth-1];
  assign rsp_o.rdata = rdata_q[Depth-1];
  assign rsp_o.resp  = resp_q[Depth-1];

endmodule

// File: rtl/avalon_ibex_responder_mem.sv
// Avalon-MM responder with word-addressed on-chip RAM: pipelined fixed-latency
// reads, byte-enable writes, programmable wait states, read backpressure on
// outstanding responses and DECODEERROR outside the RAM.
module avalon_ibex_responder_mem
  import avalon_ibex_responder_mem_pkg::*;
#(
  parameter int AddrWidth   = 30,
  parameter int MemDepth    = 4096,
  parameter int ReadLatency = 2,
  parameter int MaxPending  = 2,
  parameter int WaitStates  = 0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  avalon_ibex_responder_mem_if.slave        avs
);

  localparam int PendW = $clog2(MaxPending + 1);
  localparam int IdxW  = $clog2(MemDepth);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STALL  = 2'd1,
    ST_ACCEPT = 2'd2
  } ws_state_e;

  ws_state_e            state_q;
  logic [3:0]           ws_cnt_q;
  logic [PendW-1:0]     pend_q;
  logic [DataWidth-1:0] mem_q [MemDepth];

  logic            cmd_s;
  logic            pend_full_s;
  logic            waitrequest_s;
  logic            accept_s;
  logic            rd_acc_s;
  logic            mem_we_s;
  logic            in_range_s;
  logic [IdxW-1:0] mem_idx_s;
  rsp_t            rsp_in_s;
  rsp_t            rsp_out_s;

  assign cmd_s       = avs.avs_read | avs.avs_write;
  assign pend_full_s = (pend_q == PendW'(MaxPending));
  // The pending-full stall uses the registered count, so a response leaving
  // in the same cycle does not release the stall early.
  assign waitrequest_s = rst_i | (pend_full_s & avs.avs_read) |
                         (ws_cnt_q != 4'(WaitStates));
  assign accept_s   = cmd_s & ~waitrequest_s;
  // read&write together is a protocol error: it takes a response slot but
  // never touches the RAM.
  assign rd_acc_s   = accept_s & avs.avs_read;
  // Full-width compare so high address bits never alias into the RAM.
  assign in_range_s = (avs.avs_address < AddrWidth'(MemDepth));
  assign mem_idx_s  = avs.avs_address[IdxW-1:0];
  assign mem_we_s   = accept_s & avs.avs_write & ~avs.avs_read & in_range_s;

  // Wait-state sequencer: hold waitrequest WaitStates cycles per new command.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ws_cnt_q <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_s && (WaitStates > 0)) begin
            ws_cnt_q <= 4'd1;
            state_q  <= (WaitStates == 1) ? ST_ACCEPT : ST_STALL;
          end
        end
        ST_STALL: begin
          ws_cnt_q <= ws_cnt_q + 4'd1;
          if ((ws_cnt_q + 4'd1) == 4'(WaitStates)) begin
            state_q <= ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          // Stay here while a read is held off by the pending limit.
          if (accept_s || !cmd_s) begin
            state_q  <= ST_IDLE;
            ws_cnt_q <= 4'd0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          ws_cnt_q <= 4'd0;
        end
      endcase
    end
  end

  // Outstanding-read counter: +1 on read accept, -1 on response delivery.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
    end else begin
      case ({rd_acc_s, rsp_out_s.valid})
        2'b10:   pend_q <= pend_q + PendW'(1);
        2'b01:   pend_q <= pend_q - PendW'(1);
        default: pend_q <= pend_q;
      endcase
    end
  end

  // RAM byte-lane writes; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      mem_q[mem_idx_s] <= be_merge(mem_q[mem_idx_s], avs.avs_writedata,
                                   avs.avs_byteenable);
    end
  end

  // Build the response entry for an accepted read at acceptance time.
  always_comb begin
    rsp_in_s = '0;
    if (rd_acc_s) begin
      rsp_in_s.valid = 1'b1;
      if (avs.avs_write) begin
        rsp_in_s.resp = SLAVEERROR;
      end else if (in_range_s) begin
        rsp_in_s.rdata = mem_q[mem_idx_s];
        rsp_in_s.resp  = OKAY;
      end else begin
        rsp_in_s.resp = DECODEERROR;
      end
    end else begin
      rsp_in_s = '0;
    end
  end

  avalon_ibex_responder_mem_rsp_pipe #(
    .Depth (ReadLatency)
  ) u_rsp_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rsp_i (rsp_in_s),
    .rsp_o (rsp_out_s)
  );

  assign avs.avs_waitrequest   = waitrequest_s;
  assign avs.avs_readdatavalid = rsp_out_s.valid;
  assign avs.avs_readdata      = rsp_out_s.valid ? rsp_out_s.rdata : 32'h0000_0000;
  assign avs.avs_response      = rsp_out_s.valid ? rsp_out_s.resp : OKAY;

endmodule

// File: tb/tb_avalon_ibex_responder_mem.sv
// Directed self-checking bench: one DUT with no wait states, one with three.
module tb_avalon_ibex_responder_mem;
  import avalon_ibex_responder_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_cyc;
  int   stall_n;
  int   pend_first;

  logic [31:0] rq_data [$];
  resp_e       rq_resp [$];
  int          rq_cyc  [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  avalon_ibex_responder_mem_if #(.AddrWidth(30)) bus0 ();
  avalon_ibex_responder_mem_if #(.AddrWidth(30)) bus3 ();

  avalon_ibex_responder_mem #(
    .AddrWidth(30), .MemDepth(4096), .ReadLatency(2), .MaxPending(2), .WaitStates(0)
  ) dut0 (.clk_i(clk), .rst_i(rst), .avs(bus0.slave));

  avalon_ibex_responder_mem #(
    .AddrWidth(30), .MemDepth(4096), .ReadLatency(2), .MaxPending(2), .WaitStates(3)
  ) dut3 (.clk_i(clk), .rst_i(rst), .avs(bus3.slave));

  always @(negedge clk) begin
    if (bus0.avs_readdatavalid === 1'b1) begin
      rq_data.push_back(bus0.avs_readdata);
      rq_resp.push_back(bus0.avs_response);
      rq_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic clr_q();
    rq_data.delete();
    rq_resp.delete();
    rq_cyc.delete();
  endtask

  task automatic set_idle0();
    bus0.avs_read = 1'b0; bus0.avs_write = 1'b0; bus0.avs_byteenable = 4'h0;
    bus0.avs_writedata = 32'h0; bus0.avs_address = 30'h0;
  endtask

  task automatic set_idle3();
    bus3.avs_read = 1'b0; bus3.avs_write = 1'b0; bus3.avs_byteenable = 4'h0;
    bus3.avs_writedata = 32'h0; bus3.avs_address = 30'h0;
  endtask

  task automatic idle0();
    @(negedge clk);
    set_idle0();
  endtask

  // Present a command on bus0 at the next negedge and hold it until accepted.
  task automatic cmd0(input logic rd, input logic wr, input logic [29:0] addr,
                      input logic [3:0] be, input logic [31:0] data);
    bit done;
    done = 1'b0;
    stall_n = 0;
    @(negedge clk);
    bus0.avs_read = rd; bus0.avs_write = wr; bus0.avs_address = addr;
    bus0.avs_byteenable = be; bus0.avs_writedata = data;
    for (int i = 0; i < 32 && !done; i++) begin
      #1;
      if (i == 0) pend_first = int'(dut0.pend_q);
      if (bus0.avs_waitrequest === 1'b0) begin
        acc_cyc = cyc;
        done = 1'b1;
        @(posedge clk);
      end else begin
        stall_n++;
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL cmd0_timeout addr=%h got=stalled req=accept", addr);
    end
  endtask

  task automatic cmd3(input logic [29:0] addr, input logic [31:0] data);
    bit done;
    done = 1'b0;
    stall_n = 0;
    @(negedge clk);
    bus3.avs_write = 1'b1; bus3.avs_address = addr;
    bus3.avs_byteenable = 4'hF; bus3.avs_writedata = data;
    for (int i = 0; i < 32 && !done; i++) begin
      #1;
      if (bus3.avs_waitrequest === 1'b0) begin
        done = 1'b1;
        @(posedge clk);
      end else begin
        stall_n++;
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL cmd3_timeout addr=%h got=stalled req=accept", addr);
    end
  endtask

  task automatic wait_rsp0(input int n);
    for (int i = 0; i < 20 && rq_data.size() < n; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus0.avs_waitrequest !== 1'b1) begin failures++; $display("FAIL rst_wait got=%b req=1", bus0.avs_waitrequest); end
    checks++; if (bus0.avs_readdatavalid !== 1'b0) begin failures++; $display("FAIL rst_rdv got=%b req=0", bus0.avs_readdatavalid); end
    checks++; if (bus0.avs_readdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h req=0", bus0.avs_readdata); end
    checks++; if (bus0.avs_response !== OKAY) begin failures++; $display("FAIL rst_resp got=%0d req=0", bus0.avs_response); end
    checks++; if (bus3.avs_waitrequest !== 1'b1) begin failures++; $display("FAIL rst_wait3 got=%b req=1", bus3.avs_waitrequest); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (bus0.avs_waitrequest !== 1'b0) begin failures++; $display("FAIL post_rst_wait got=%b req=0", bus0.avs_waitrequest); end
  endtask

  task automatic test_write_merge();
    int a;
    clr_q();
    cmd0(1'b0, 1'b1, 30'h10, 4'hF, 32'hDEADBEEF);
    cmd0(1'b0, 1'b1, 30'h10, 4'h1, 32'h000000AA);
    cmd0(1'b1, 1'b0, 30'h10, 4'h0, 32'h0);
    a = acc_cyc;
    idle0();
    wait_rsp0(1);
    checks++; if (rq_data.size() !== 1) begin failures++; $display("FAIL merge_count got=%0d req=1", rq_data.size()); end
    if (rq_data.size() >= 1) begin
      checks++; if (rq_data[0] !== 32'hDEADBEAA) begin failures++; $display("FAIL merge_data got=%h req=deadbeaa", rq_data[0]); end
      checks++; if (rq_resp[0] !== OKAY) begin failures++; $display("FAIL merge_resp got=%0d req=0", rq_resp[0]); end
      checks++; if (rq_cyc[0] - a !== 2) begin failures++; $display("FAIL merge_latency got=%0d req=2", rq_cyc[0] - a); end
    end
  endtask

  task automatic test_back_to_back();
    int st [4];
    int ac [4];
    int pf2;
    for (int i = 0; i < 4; i++) cmd0(1'b0, 1'b1, 30'(i), 4'hF, 32'hA5A5_0000 | 32'(i));
    clr_q();
    pf2 = -1;
    for (int i = 0; i < 4; i++) begin
      cmd0(1'b1, 1'b0, 30'(i), 4'h0, 32'h0);
      st[i] = stall_n;
      ac[i] = acc_cyc;
      if (i == 2) pf2 = pend_first;
    end
    idle0();
    wait_rsp0(4);
    checks++; if (pf2 !== 2) begin failures++; $display("FAIL b2b_pend_at_stall got=%0d req=2", pf2); end
    checks++; if (st[0] + st[1] + st[3] !== 0) begin failures++; $display("FAIL b2b_stall_other got=%0d req=0", st[0] + st[1] + st[3]); end
    checks++; if (st[2] !== 1) begin failures++; $display("FAIL b2b_stall_r2 got=%0d req=1", st[2]); end
    checks++; if (rq_data.size() !== 4) begin failures++; $display("FAIL b2b_count got=%0d req=4", rq_data.size()); end
    for (int i = 0; i < 4 && i < rq_data.size(); i++) begin
      checks++; if (rq_data[i] !== (32'hA5A5_0000 | 32'(i))) begin failures++; $display("FAIL b2b_data%0d got=%h req=%h", i, rq_data[i], 32'hA5A5_0000 | 32'(i)); end
      checks++; if (rq_resp[i] !== OKAY) begin failures++; $display("FAIL b2b_resp%0d got=%0d req=0", i, rq_resp[i]); end
      checks++; if (rq_cyc[i] - ac[i] !== 2) begin failures++; $display("FAIL b2b_lat%0d got=%0d req=2", i, rq_cyc[i] - ac[i]); end
    end
    checks++; if (dut0.pend_q !== 2'd0) begin failures++; $display("FAIL b2b_pend_end got=%0d req=0", dut0.pend_q); end
  endtask

  task automatic test_decode();
    clr_q();
    cmd0(1'b1, 1'b0, 30'h1000, 4'h0, 32'h0);
    cmd0(1'b0, 1'b1, 30'h1000, 4'hF, 32'hFFFFFFFF);
    cmd0(1'b1, 1'b0, 30'h0, 4'h0, 32'h0);
    cmd0(1'b1, 1'b0, 30'h2000_0000, 4'h0, 32'h0);
    idle0();
    wait_rsp0(3);
    checks++; if (rq_data.size() !== 3) begin failures++; $display("FAIL dec_count got=%0d req=3", rq_data.size()); end
    if (rq_data.size() >= 3) begin
      checks++; if (rq_data[0] !== 32'h0) begin failures++; $display("FAIL dec_data got=%h req=0", rq_data[0]); end
      checks++; if (rq_resp[0] !== DECODEERROR) begin failures++; $display("FAIL dec_resp got=%0d req=3", rq_resp[0]); end
      checks++; if (rq_data[1] !== 32'hA5A5_0000) begin failures++; $display("FAIL dec_ram0 got=%h req=a5a50000", rq_data[1]); end
      checks++; if (rq_resp[1] !== OKAY) begin failures++; $display("FAIL dec_ram0_resp got=%0d req=0", rq_resp[1]); end
      checks++; if (rq_data[2] !== 32'h0) begin failures++; $display("FAIL dec_alias_data got=%h req=0", rq_data[2]); end
      checks++; if (rq_resp[2] !== DECODEERROR) begin failures++; $display("FAIL dec_alias_resp got=%0d req=3", rq_resp[2]); end
    end
  endtask

  task automatic test_proto_err();
    cmd0(1'b0, 1'b1, 30'h5, 4'hF, 32'h55667788);
    clr_q();
    cmd0(1'b1, 1'b1, 30'h5, 4'hF, 32'hFFFFFFFF);
    cmd0(1'b1, 1'b0, 30'h5, 4'h0, 32'h0);
    idle0();
    wait_rsp0(2);
    checks++; if (rq_data.size() !== 2) begin failures++; $display("FAIL perr_count got=%0d req=2", rq_data.size()); end
    if (rq_data.size() >= 2) begin
      checks++; if (rq_data[0] !== 32'h0) begin failures++; $display("FAIL perr_data got=%h req=0", rq_data[0]); end
      checks++; if (rq_resp[0] !== SLAVEERROR) begin failures++; $display("FAIL perr_resp got=%0d req=2", rq_resp[0]); end
      checks++; if (rq_data[1] !== 32'h55667788) begin failures++; $display("FAIL perr_ram5 got=%h req=55667788", rq_data[1]); end
      checks++; if (rq_resp[1] !== OKAY) begin failures++; $display("FAIL perr_ram5_resp got=%0d req=0", rq_resp[1]); end
    end
  endtask

  task automatic test_wait_states();
    cmd3(30'h20, 32'h12345678);
    checks++; if (stall_n !== 3) begin failures++; $display("FAIL ws_first got=%0d req=3", stall_n); end
    cmd3(30'h21, 32'h9ABCDEF0);
    checks++; if (stall_n !== 3) begin failures++; $display("FAIL ws_second got=%0d req=3", stall_n); end
    @(negedge clk);
    set_idle3();
    @(negedge clk);
    checks++; if (dut3.mem_q[32] !== 32'h12345678) begin failures++; $display("FAIL ws_mem20 got=%h req=12345678", dut3.mem_q[32]); end
    checks++; if (dut3.mem_q[33] !== 32'h9ABCDEF0) begin failures++; $display("FAIL ws_mem21 got=%h req=9abcdef0", dut3.mem_q[33]); end
  endtask

  task automatic test_reset_mid();
    cmd0(1'b0, 1'b1, 30'h10, 4'hF, 32'hCAFEF00D);
    cmd0(1'b1, 1'b0, 30'h0, 4'h0, 32'h0);
    cmd0(1'b1, 1'b0, 30'h1, 4'h0, 32'h0);
    @(negedge clk);
    set_idle0();
    rst = 1'b1;
    @(posedge clk);
    #1;
    clr_q();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (bus0.avs_waitrequest !== 1'b1) begin failures++; $display("FAIL rmid_wait%0d got=%b req=1", i, bus0.avs_waitrequest); end
      checks++; if (bus0.avs_readdatavalid !== 1'b0) begin failures++; $display("FAIL rmid_rdv%0d got=%b req=0", i, bus0.avs_readdatavalid); end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (dut0.pend_q !== 2'd0) begin failures++; $display("FAIL rmid_pend got=%0d req=0", dut0.pend_q); end
    repeat (5) @(negedge clk);
    checks++; if (rq_data.size() !== 0) begin failures++; $display("FAIL rmid_dropped got=%0d req=0", rq_data.size()); end
    clr_q();
    cmd0(1'b1, 1'b0, 30'h10, 4'h0, 32'h0);
    idle0();
    wait_rsp0(1);
    checks++; if (rq_data.size() !== 1) begin failures++; $display("FAIL rmid_count got=%0d req=1", rq_data.size()); end
    if (rq_data.size() >= 1) begin
      checks++; if (rq_data[0] !== 32'hCAFEF00D) begin failures++; $display("FAIL rmid_data got=%h req=cafef00d", rq_data[0]); end
      checks++; if (rq_resp[0] !== OKAY) begin failures++; $display("FAIL rmid_resp got=%0d req=0", rq_resp[0]); end
    end
  endtask

  initial begin
    set_idle0();
    set_idle3();
    test_reset();
    test_write_merge();
    test_back_to_back();
    test_decode();
    test_proto_err();
    test_wait_states();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
